ctrl_pulse_gen: RTL and testbench

Front-end control stage for the 3-bit counter. Takes two raw, bouncy, asynchronous pushbutton inputs and produces the counter's `set` and `load` controls.
- Each raw input is synchronised, debounced and edge-detected into a clean single-cycle pulse.
- The two outputs are never asserted in the same cycle.
- Debounced button levels are exported for status LEDs.
- Outputs connect directly to the counter's set/load inputs.

---
 rtl/ctrl_pulse_gen_if.sv | 29 ++
 rtl/ctrl_pulse_gen.sv | 209 ++++++++++++++++++++
 tb/tb_ctrl_pulse_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pulse_gen_if.sv
// Button/pulse bundle for ctrl_pulse_gen.
// master: the side driving the raw buttons (board, bench).
// slave : the pulse generator itself.
interface ctrl_pulse_gen_if;
  logic set_btn;    // raw set button, asynchronous, active-high
  logic load_btn;   // raw load button, asynchronous, active-high
  logic set;        // single-cycle set pulse to the counter
  logic load;       // single-cycle load pulse to the counter
  logic set_held;   // debounced set level (status LED)
  logic load_held;  // debounced load level (status LED)

  modport master (
    output set_btn,
    output load_btn,
    input  set,
    input  load,
    input  set_held,
    input  load_held
  );

  modport slave (
    input  set_btn,
    input  load_btn,
    output set,
    output load,
    output set_held,
    output load_held
  );
endinterface

// File: rtl/ctrl_pulse_gen.sv
// ctrl_pulse_gen: front-end control stage for the 3-bit counter.
// Two raw pushbuttons are synchronised, debounced and edge-detected into
// single-cycle set/load pulses. The two pulses never overlap: a collision is
// resolved by deferring the loser one cycle in a one-deep pending flag.
// Optional feature macro: LOAD_AUTOREPEAT_EN -- while the load button stays
// accepted, a further load event is raised every REPEAT_CYCLES cycles.
module ctrl_pulse_gen #(
  parameter int DB_CYCLES     = 4,   // stable samples needed to accept a change
  parameter int CNT_W         = 8,   // debounce counter width
  parameter int REPEAT_CYCLES = 16   // load auto-repeat interval
) (
  input  logic            clk,
  input  logic            reset,     // asynchronous, active-low
  ctrl_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_db
    $error("ctrl_pulse_gen: DB_CYCLES must be in 2..255");
  end
  if ((DB_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("ctrl_pulse_gen: CNT_W too narrow for DB_CYCLES-1");
  end
  if (REPEAT_CYCLES < 4) begin : g_bad_rpt
    $error("ctrl_pulse_gen: REPEAT_CYCLES must be >= 4");
  end

  // Channel 0 = set, channel 1 = load
  logic [1:0] raw_btn;
  logic [1:0] chan_evt;   // accepted press (or repeat) this cycle
  logic [1:0] chan_held;  // debounced level

  assign raw_btn = {bus.load_btn, bus.set_btn};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_ch
    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_evt;
    logic             rpt_evt;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw_btn[gi];
        sync2_q <= sync1_q;
      end
    end

    // Debounce FSM state and stability counter
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Debounce next-state: a change is accepted only after DB_CYCLES
    // consecutive synchronised samples disagree with the current level;
    // the counter never passes CNT_LAST because reaching it leaves the wait.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_evt = 1'b0;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (sync2_q) begin
            cnt_d   = CNT_W'(1);
            state_d = PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (sync2_q) begin
            if (cnt_q >= CNT_LAST) begin
              state_d   = PRESSED;
              cnt_d     = '0;
              press_evt = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            // glitch shorter than the debounce window: no pulse
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        PRESSED: begin
          cnt_d = '0;
          if (!sync2_q) begin
            cnt_d   = CNT_W'(1);
            state_d = REL_WAIT;
          end
        end
        REL_WAIT: begin
          if (!sync2_q) begin
            if (cnt_q >= CNT_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            // release bounce: back to held, no new event
            cnt_d   = '0;
            state_d = PRESSED;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef LOAD_AUTOREPEAT_EN
    if (gi == 1) begin : g_rpt
      localparam int RPT_W = $clog2(REPEAT_CYCLES);
      localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
      logic [RPT_W-1:0] rpt_q;
      logic [RPT_W-1:0] rpt_d;

      // Repeat counter runs only while PRESSED, restarts after each repeat
      always_comb begin
        rpt_d = '0;
        if (state_q == PRESSED && rpt_q != RPT_LAST) begin
          rpt_d = rpt_q + 1'b1;
        end
      end

      // Repeat counter register
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rpt_q <= '0;
        end else begin
          rpt_q <= rpt_d;
        end
      end

      assign rpt_evt = (state_q == PRESSED) && (rpt_q == RPT_LAST);
    end else begin : g_no_rpt
      assign rpt_evt = 1'b0;
    end
`else
    assign rpt_evt = 1'b0;
`endif

    assign chan_evt[gi]  = press_evt | rpt_evt;
    assign chan_held[gi] = (state_q == PRESSED) || (state_q == REL_WAIT);
  end

  // Arbitration between the two channels
  logic set_q, set_d;
  logic load_q, load_d;
  logic set_pend_q, set_pend_d;
  logic load_pend_q, load_pend_d;
  logic set_req, load_req;

  // A pending request beats a fresh one on the other channel; two fresh
  // requests go to set first. The loser waits one cycle in its pend flag.
  always_comb begin
    set_req     = set_pend_q | chan_evt[0];
    load_req    = load_pend_q | chan_evt[1];
    set_d       = set_req & ~(load_req & load_pend_q & ~set_pend_q);
    load_d      = load_req & ~set_d;
    set_pend_d  = set_req & ~set_d;
    load_pend_d = load_req & ~load_d;
  end

  // Registered pulse outputs and pending flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_q       <= 1'b0;
      load_q      <= 1'b0;
      set_pend_q  <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      set_q       <= set_d;
      load_q      <= load_d;
      set_pend_q  <= set_pend_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign bus.set       = set_q;
  assign bus.load      = load_q;
  assign bus.set_held  = chan_held[0];
  assign bus.load_held = chan_held[1];

endmodule

// File: tb/tb_ctrl_pulse_gen.sv
// Self-checking bench for ctrl_pulse_gen: directed scenarios plus a random
// bouncy-button run against a run-length / FIFO reference model.
module tb_ctrl_pulse_gen;
  localparam int DB  = 4;
  localparam int CW  = 8;
  localparam int RPT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ctrl_pulse_gen_if bus ();

  ctrl_pulse_gen #(
    .DB_CYCLES    (DB),
    .CNT_W        (CW),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a level flips after DB consecutive synchronised samples
  // that disagree with it; accepted events are served oldest-first, one per
  // cycle, set before load when simultaneous.
  bit m_s1[2];
  bit m_s2[2];
  bit m_held[2];
  int m_run[2];
  int m_q[$];
  bit m_set;
  bit m_load;
`ifdef LOAD_AUTOREPEAT_EN
  int m_rpt;
`endif

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_held[c] = 0; m_run[c] = 0;
    end
    m_q.delete();
    m_set = 0;
    m_load = 0;
`ifdef LOAD_AUTOREPEAT_EN
    m_rpt = 0;
`endif
  endtask

  task automatic model_step();
    bit ev[2];
    bit raw[2];
    raw[0] = bus.set_btn;
    raw[1] = bus.load_btn;
    ev[0] = 0;
    ev[1] = 0;
`ifdef LOAD_AUTOREPEAT_EN
    // cycles spent accepted with no release pending
    if (m_held[1] && m_run[1] == 0) begin
      m_rpt++;
      if (m_rpt == RPT) begin
        ev[1] = 1;
        m_rpt = 0;
      end
    end else begin
      m_rpt = 0;
    end
`endif
    for (int c = 0; c < 2; c++) begin
      if (m_s2[c] != m_held[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_held[c] = m_s2[c];
          m_run[c] = 0;
          if (m_held[c]) ev[c] = 1;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    if (ev[0]) m_q.push_back(0);
    if (ev[1]) m_q.push_back(1);
    m_set = 0;
    m_load = 0;
    if (m_q.size() > 0) begin
      if (m_q.pop_front() == 0) m_set = 1;
      else m_load = 1;
    end
    for (int c = 0; c < 2; c++) begin
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    else model_reset();
    cyc++;
    #1;
  endtask

  task automatic settle();
    bus.set_btn = 0;
    bus.load_btn = 0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    reset = 0;
    bus.set_btn = 0;
    bus.load_btn = 0;
    model_reset();
    repeat (3) tick();
    n_checks++;
    if (bus.set !== 1'b0) begin n_fail++; $display("FAIL reset_set got=%b exp=0", bus.set); end
    n_checks++;
    if (bus.load !== 1'b0) begin n_fail++; $display("FAIL reset_load got=%b exp=0", bus.load); end
    n_checks++;
    if (bus.set_held !== 1'b0) begin n_fail++; $display("FAIL reset_set_held got=%b exp=0", bus.set_held); end
    n_checks++;
    if (bus.load_held !== 1'b0) begin n_fail++; $display("FAIL reset_load_held got=%b exp=0", bus.load_held); end
    reset = 1;
    repeat (3) tick();
    $display("test_reset done, failures so far %0d", n_fail);
  endtask

  task automatic test_single_press();
    int k, pulses, pcyc;
    bit exp_h;
    pulses = 0;
    pcyc = -1;
    bus.set_btn = 1;
    k = cyc + 1;
    repeat (40) begin
      tick();
      if (bus.set === 1'b1) begin pulses++; pcyc = cyc; end
      exp_h = (cyc >= k + DB + 1);
      n_checks++;
      if (bus.set_held !== exp_h) begin
        n_fail++; $display("FAIL single_held cyc=%0d got=%b exp=%b", cyc, bus.set_held, exp_h);
      end
      n_checks++;
      if (bus.load !== 1'b0) begin n_fail++; $display("FAIL single_load cyc=%0d got=%b exp=0", cyc, bus.load); end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", pulses); end
    n_checks++;
    if (pcyc != k + DB + 1) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", pcyc, k + DB + 1); end
    settle();
    $display("test_single_press done, pulse at %0d, failures so far %0d", pcyc, n_fail);
  endtask

  task automatic test_glitch();
    bit pat[12];
    pat = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      bus.load_btn = pat[i];
      tick();
      n_checks++;
      if (bus.load !== 1'b0) begin n_fail++; $display("FAIL glitch_load cyc=%0d got=%b exp=0", cyc, bus.load); end
      n_checks++;
      if (bus.load_held !== 1'b0) begin n_fail++; $display("FAIL glitch_held cyc=%0d got=%b exp=0", cyc, bus.load_held); end
    end
    settle();
    $display("test_glitch done, failures so far %0d", n_fail);
  endtask

  task automatic test_bounce();
    int c0, k, j, pulses, pcyc, fall;
    bit v, seen_h;
    c0 = cyc;
    k = c0 + 7;    // first edge of the steady press
    j = c0 + 29;   // first edge of the steady release
    pulses = 0; pcyc = -1; fall = -1; seen_h = 0;
    for (int i = 0; i < 42; i++) begin
      if (i < 6) v = (i % 2 == 0);
      else if (i < 26) v = 1;
      else if (i == 27) v = 1;
      else v = 0;
      bus.set_btn = v;
      tick();
      if (bus.set === 1'b1) begin pulses++; pcyc = cyc; end
      if (bus.set_held === 1'b1) seen_h = 1;
      else if (seen_h && fall < 0) fall = cyc;
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL bounce_count got=%0d exp=1", pulses); end
    n_checks++;
    if (pcyc != k + DB + 1) begin n_fail++; $display("FAIL bounce_latency got=%0d exp=%0d", pcyc, k + DB + 1); end
    n_checks++;
    if (fall != j + DB + 1) begin n_fail++; $display("FAIL bounce_release got=%0d exp=%0d", fall, j + DB + 1); end
    settle();
    $display("test_bounce done, pulse %0d release %0d, failures so far %0d", pcyc, fall, n_fail);
  endtask

  task automatic test_simultaneous();
    int k, scyc, lcyc, sn, ln;
    scyc = -1; lcyc = -1; sn = 0; ln = 0;
    bus.set_btn = 1;
    bus.load_btn = 1;
    k = cyc + 1;
    repeat (20) begin
      tick();
      if (bus.set === 1'b1) begin sn++; scyc = cyc; end
      if (bus.load === 1'b1) begin ln++; lcyc = cyc; end
      n_checks++;
      if (bus.set === 1'b1 && bus.load === 1'b1) begin
        n_fail++; $display("FAIL simul_overlap cyc=%0d got set=1 load=1 exp not both", cyc);
      end
    end
    n_checks++;
    if (sn != 1 || scyc != k + DB + 1) begin
      n_fail++; $display("FAIL simul_set got n=%0d cyc=%0d exp n=1 cyc=%0d", sn, scyc, k + DB + 1);
    end
    n_checks++;
    if (ln != 1 || lcyc != k + DB + 2) begin
      n_fail++; $display("FAIL simul_load got n=%0d cyc=%0d exp n=1 cyc=%0d", ln, lcyc, k + DB + 2);
    end
    settle();
    $display("test_simultaneous done, set %0d load %0d, failures so far %0d", scyc, lcyc, n_fail);
  endtask

  task automatic test_reset_mid();
    int k2, pulses, pcyc;
    pulses = 0; pcyc = -1;
    bus.set_btn = 1;
    repeat (3) tick();
    reset = 0;
    model_reset();
    #1;
    n_checks++;
    if ({bus.set, bus.load, bus.set_held, bus.load_held} !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_outputs got=%b exp=0000", {bus.set, bus.load, bus.set_held, bus.load_held});
    end
    repeat (2) begin
      tick();
      if (bus.set === 1'b1) pulses++;
    end
    reset = 1;
    k2 = cyc + 1;
    repeat (20) begin
      tick();
      if (bus.set === 1'b1) begin pulses++; pcyc = cyc; end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL midreset_count got=%0d exp=1", pulses); end
    n_checks++;
    if (pcyc != k2 + DB + 1) begin n_fail++; $display("FAIL midreset_latency got=%0d exp=%0d", pcyc, k2 + DB + 1); end
    settle();
    $display("test_reset_mid done, pulse at %0d, failures so far %0d", pcyc, n_fail);
  endtask

  task automatic test_autorepeat();
    int a;
    int got[$];
    int expq[$];
    bus.load_btn = 1;
    a = cyc + 1 + DB + 1;
    while (cyc < a + 50) begin
      tick();
      if (bus.load === 1'b1) got.push_back(cyc);
    end
`ifdef LOAD_AUTOREPEAT_EN
    for (int t = a; t <= a + 50; t += RPT) expq.push_back(t);
`else
    expq.push_back(a);
`endif
    n_checks++;
    if (got.size() != expq.size()) begin
      n_fail++; $display("FAIL repeat_count got=%0d exp=%0d", got.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        n_checks++;
        if (got[i] != expq[i]) begin
          n_fail++; $display("FAIL repeat_pulse%0d got=%0d exp=%0d", i, got[i], expq[i]);
        end
      end
    end
    settle();
    $display("test_autorepeat done, %0d load pulses, failures so far %0d", got.size(), n_fail);
  endtask

  task automatic test_random();
    int seg[2];
    bit lvl[2];
    int errs_before;
    errs_before = n_fail;
    seg[0] = 0; seg[1] = 0; lvl[0] = 0; lvl[1] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (seg[c] == 0) begin
          lvl[c] = ~lvl[c];
          seg[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 14);
        end
        seg[c]--;
      end
      bus.set_btn = lvl[0];
      bus.load_btn = lvl[1];
      if (n == 700) begin
        reset = 0;
        model_reset();
      end
      if (n == 703) reset = 1;
      tick();
      n_checks++;
      if (bus.set !== m_set) begin n_fail++; $display("FAIL rand_set cyc=%0d got=%b exp=%b", cyc, bus.set, m_set); end
      n_checks++;
      if (bus.load !== m_load) begin n_fail++; $display("FAIL rand_load cyc=%0d got=%b exp=%b", cyc, bus.load, m_load); end
      n_checks++;
      if (bus.set_held !== m_held[0]) begin n_fail++; $display("FAIL rand_set_held cyc=%0d got=%b exp=%b", cyc, bus.set_held, m_held[0]); end
      n_checks++;
      if (bus.load_held !== m_held[1]) begin n_fail++; $display("FAIL rand_load_held cyc=%0d got=%b exp=%b", cyc, bus.load_held, m_held[1]); end
      n_checks++;
      if (bus.set === 1'b1 && bus.load === 1'b1) begin
        n_fail++; $display("FAIL rand_overlap cyc=%0d got set=1 load=1 exp not both", cyc);
      end
    end
    settle();
    $display("test_random done, %0d new failures", n_fail - errs_before);
  endtask

  initial begin
    bus.set_btn = 0;
    bus.load_btn = 0;
    test_reset();
    test_single_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_autorepeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
